// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer/FIFO-write bundle for the shared write-port arbiter
interface fifo_write_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic            arb_en;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic            grant_vld;
    logic [2:0]      grant_id;
    logic            locked;

    // Producers and FIFO side drive the requests and the full flag
    modport master (
        output arb_en, req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id, locked
    );

    // Arbiter side
    modport slave (
        input  arb_en, req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id, locked
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-locking arbiter for a shared FIFO write port
module fifo_write_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_write_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [2:0]    owner;
    logic [2:0]    rr_ptr;
    logic [3:0]    beat_cnt;
    logic          locked_q;

    logic [2:0]    winner;
    logic          win_found;
    logic          owner_valid;
    logic          sel_vld;
    logic [2:0]    sel_id;
    logic          xfer;
    logic [N-1:0]  ready;
    logic [DW-1:0] wr_data;

    // Pointers wrap at N rather than at the 3-bit field width
    function automatic logic [2:0] wrap_inc(input logic [2:0] x);
        return (x == 3'(N - 1)) ? 3'd0 : x + 3'd1;
    endfunction

    // First valid requester found by scanning from rr_ptr upward, wrapping mod N
    always_comb begin
        winner    = 3'd0;
        win_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!win_found && bus.req_valid[i] && (i == (int'(rr_ptr) + k) % N)) begin
                    win_found = 1'b1;
                    winner    = 3'(i);
                end
            end
        end
    end

    // Valid bit of the current lock owner
    always_comb begin
        owner_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (owner == 3'(i)) owner_valid = bus.req_valid[i];
        end
    end

    // Grant selection: the lock owner holds the port, otherwise the round-robin winner if allowed
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 3'd0;
        if (!reset) begin
            if (state == LOCK) begin
                sel_vld = owner_valid;
                sel_id  = owner_valid ? owner : 3'd0;
            end else if (bus.arb_en && win_found) begin
                sel_vld = 1'b1;
                sel_id  = winner;
            end
        end
    end

    assign xfer = sel_vld & ~bus.fifo_full;

    // Same-cycle handshake and write-data steering for the granted requester
    always_comb begin
        ready   = '0;
        wr_data = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_vld && (sel_id == 3'(i))) begin
                ready[i] = ~bus.fifo_full;
                wr_data  = bus.req_data[i*DW +: DW];
            end
        end
    end

    assign bus.req_ready    = ready;
    assign bus.fifo_wr_en   = |(bus.req_valid & ready);
    assign bus.fifo_wr_data = wr_data;
    assign bus.grant_vld    = sel_vld;
    assign bus.grant_id     = sel_id;
    assign bus.locked       = locked_q;

    // Grant FSM: open a lock on the first beat, release on burst end or when the owner drops valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            locked_q <= 1'b0;
            owner    <= 3'd0;
            rr_ptr   <= 3'd0;
            beat_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (MAX_BURST == 1) begin
                            rr_ptr <= wrap_inc(winner);
                        end else begin
                            state    <= LOCK;
                            locked_q <= 1'b1;
                            owner    <= winner;
                            beat_cnt <= 4'd1;
                        end
                    end
                end
                LOCK: begin
                    if (!owner_valid) begin
                        state    <= IDLE;
                        locked_q <= 1'b0;
                        rr_ptr   <= wrap_inc(owner);
                        beat_cnt <= 4'd0;
                    end else if (!bus.fifo_full) begin
                        if (beat_cnt + 4'd1 == 4'(MAX_BURST)) begin
                            state    <= IDLE;
                            locked_q <= 1'b0;
                            rr_ptr   <= wrap_inc(owner);
                            beat_cnt <= 4'd0;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    typedef struct packed {
        logic       locked;
        logic       wr_en;
        logic       gv;
        logic [2:0] id;
        logic [3:0] ready;
        logic [7:0] data;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.N(N), .DW(DW)) bus();

    fifo_write_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int passed = 0;

    obs_t exp_q[$];

    // Reference model: who holds the port, how many beats it has used, where the next search starts
    int m_holder = -1;
    int m_used   = 0;
    int m_next   = 0;
    int seq[N];
    int seen[N];
    int model_xfers = 0;
    int dut_writes  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] data_of(input int i);
        return 8'((i % 4) * 64 + (seq[i] % 64));
    endfunction

    function automatic bit vbit(input logic [3:0] v, input int i);
        logic [1:0] ix;
        ix = 2'(i);
        return v[ix];
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = {bus.locked, bus.fifo_wr_en, bus.grant_vld, bus.grant_id, bus.req_ready, bus.fifo_wr_data};
        return o;
    endfunction

    // One cycle of stimulus: drive inputs at the falling edge, predict the response, queue it
    task automatic cycle(input logic r, input logic a, input logic [3:0] v, input logic f);
        obs_t e;
        int   gid;
        bit   gv;
        bit   xfer;
        bit   found;
        int   cand;
        logic [1:0] gix;
        @(negedge clk);
        reset         = r;
        bus.arb_en    = a;
        bus.req_valid = v;
        bus.fifo_full = f;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data_of(i);
        e = '0;
        if (r) begin
            m_holder = -1;
            m_used   = 0;
            m_next   = 0;
        end else begin
            gv    = 1'b0;
            gid   = 0;
            found = 1'b0;
            if (m_holder >= 0) begin
                gv  = vbit(v, m_holder);
                gid = gv ? m_holder : 0;
            end else if (a) begin
                for (int k = 0; k < N; k++) begin
                    cand = (m_next + k) % N;
                    if (!found && vbit(v, cand)) begin
                        found = 1'b1;
                        gid   = cand;
                    end
                end
                gv = found;
            end
            xfer     = gv && !f;
            gix      = 2'(gid);
            e.locked = (m_holder >= 0);
            if (gv) begin
                e.gv   = 1'b1;
                e.id   = 3'(gid);
                e.data = data_of(gid);
            end
            if (xfer) begin
                e.wr_en     = 1'b1;
                e.ready[gix] = 1'b1;
                seq[gid]++;
                model_xfers++;
            end
            if (m_holder >= 0) begin
                if (!gv) begin
                    m_next   = (m_holder + 1) % N;
                    m_holder = -1;
                    m_used   = 0;
                end else if (xfer) begin
                    m_used++;
                    if (m_used == MAXB) begin
                        m_next   = (m_holder + 1) % N;
                        m_holder = -1;
                        m_used   = 0;
                    end
                end
            end else if (xfer) begin
                if (MAXB == 1) m_next = (gid + 1) % N;
                else begin
                    m_holder = gid;
                    m_used   = 1;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: pop the prediction for each cycle and compare against what the DUT presents
    initial begin
        obs_t o;
        obs_t e;
        logic [1:0] wid;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                o = observe();
                check("cycle_outputs", 32'(o), 32'(e));
                if (bus.fifo_wr_en) begin
                    check("no_write_when_full", {31'b0, bus.fifo_full}, 32'd0);
                    wid = bus.fifo_wr_data[7:6];
                    check("per_requester_order", 32'(bus.fifo_wr_data[5:0]), 32'(seen[wid] % 64));
                    seen[wid]++;
                    dut_writes++;
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.arb_en    = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            seen[i] = 0;
        end

        // Reset state and idle with nothing valid
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        #1 check("reset_outputs", 32'(observe()), 32'd0);
        cycle(1'b0, 1'b1, 4'b0000, 1'b0);
        #1 check("idle_no_valid", 32'(observe()), 32'd0);

        // T1: reset in the middle of a burst, then release with requester 2 valid
        cycle(1'b0, 1'b1, 4'b0001, 1'b0);
        cycle(1'b0, 1'b1, 4'b0001, 1'b0);
        #1 check("t1_locked_before_reset", {31'b0, bus.locked}, 32'd1);
        cycle(1'b1, 1'b1, 4'b0001, 1'b0);
        #1 check("t1_reset_mid_burst", 32'(observe()), 32'd0);
        cycle(1'b0, 1'b1, 4'b0100, 1'b0);
        #1 check("t1_release_grant", {28'b0, bus.fifo_wr_en, bus.grant_id}, {28'b0, 1'b1, 3'd2});

        // T2: all requesters valid, four beats each in rotation
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, 4'b1111, 1'b0);
            #1 check("t2_rotation", {28'b0, bus.fifo_wr_en, bus.grant_id}, {28'b0, 1'b1, 3'((k / 4) % 4)});
        end

        // T3: requester 1 stalls by a full FIFO at beat 2, finishes its burst, then 2 follows
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 4'b0110, 1'b0);
            #1 check("t3_first_beats", {28'b0, bus.fifo_wr_en, bus.grant_id}, {28'b0, 1'b1, 3'd1});
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 4'b0110, 1'b1);
            #1 check("t3_stall", {24'b0, bus.fifo_wr_en, bus.req_ready, bus.grant_id},
                     {24'b0, 1'b0, 4'b0000, 3'd1});
            check("t3_stall_locked", {31'b0, bus.locked}, 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 4'b0110, 1'b0);
            #1 check("t3_resume", {28'b0, bus.fifo_wr_en, bus.grant_id}, {28'b0, 1'b1, 3'd1});
        end
        cycle(1'b0, 1'b1, 4'b0110, 1'b0);
        #1 check("t3_rotate", {27'b0, bus.locked, bus.fifo_wr_en, bus.grant_id}, {27'b0, 1'b0, 1'b1, 3'd2});

        // T4: owner 3 drops valid after two beats; pointer wraps to requester 0
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 1'b1, 4'b1000, 1'b0);
            #1 check("t4_owner3", {28'b0, bus.fifo_wr_en, bus.grant_id}, {28'b0, 1'b1, 3'd3});
        end
        cycle(1'b0, 1'b1, 4'b0001, 1'b0);
        #1 check("t4_drop", {29'b0, bus.locked, bus.grant_vld, bus.fifo_wr_en}, {29'b0, 3'b100});
        cycle(1'b0, 1'b1, 4'b0001, 1'b0);
        #1 check("t4_wrap", {27'b0, bus.locked, bus.fifo_wr_en, bus.grant_id}, {27'b0, 1'b0, 1'b1, 3'd0});

        // T5: arb_en low lets the running burst finish, then blocks new grants
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 1'b1, 4'b0001, 1'b0);
        #1 check("t5_first", {28'b0, bus.fifo_wr_en, bus.grant_id}, {28'b0, 1'b1, 3'd0});
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 4'b1111, 1'b0);
            #1 check("t5_burst_completes", {28'b0, bus.fifo_wr_en, bus.grant_id}, {28'b0, 1'b1, 3'd0});
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 4'b1111, 1'b0);
            #1 check("t5_no_grant", {30'b0, bus.grant_vld, bus.fifo_wr_en}, 32'd0);
        end

        // T6: random valid/full/arb_en traffic with occasional resets
        cycle(1'b1, 1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 10000; k++) begin
            cycle(($urandom_range(0, 999) == 0),
                  ($urandom_range(0, 9) != 0),
                  4'($urandom),
                  ($urandom_range(0, 3) == 0));
        end
        cycle(1'b0, 1'b1, 4'b0000, 1'b0);

        @(negedge clk);
        #5;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("write_count", 32'(dut_writes), 32'(model_xfers));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
